cpu_control: RTL and testbench
==============================

// Module: cpu_control
// PURPOSE
//  Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
//  - Fetches 16-bit instructions from a sync-read program ROM.
//  - Fetches memory operands from, and stores to, a sync-read data RAM.
//  - Drives the alu (enable, op, A/B/C operands) and owns the accumulator, PC and C/Z/N flags.
// PARAMETERS
//  PC_WIDTH         8  program address width; PC wraps modulo 2**PC_WIDTH
//  DADDR_WIDTH      8  data RAM address width; operand[DADDR_WIDTH-1:0] used
// PORTS
//  _iClk        in   1           clock
//  _iReset      in   1           synchronous, active-high reset
//  _oPAddr      out  PC_WIDTH    program ROM address (= PC)
//  _iPData      in   16          ROM data; valid the cycle after _oPAddr
//  _oDAddr      out  DADDR_WIDTH data RAM address (= IR operand)
//  _oDWe        out  1           data RAM write strobe
//  _oDWData     out  8           data RAM write data (= accumulator)
//  _iDRData     in   8           RAM read data; valid the cycle after _oDAddr
//  _oAluEn      out  1           alu enable
//  _oAluOp      out  Operation   alu operation
//  _oAluA/_oAluB/_oAluC  out 8/8/1  accumulator / operand register / carry flag
//  _iAluResult  in   8           alu result; valid the cycle after _oAluEn
//  _iAluCarry/_iAluZero/_iAluNeg  in 1 each  alu flags, same timing as result
//  _oAcc/_oPc   out  8/PC_WIDTH  observation
//  _oHalted     out  1           high in HALT state
// BEHAVIOUR
//  Instr: [15:12] opcode, [11] M (1 = operand from RAM[op], 0 = immediate), [10:8] ignored, [7:0] op.
//  Opcodes:
//   - 0 NOP, 1 LD, 2 ST, 3 ADD, 4 SUB, 5 NOR, 6 NAND, 7 XOR, 8 XNOR.
//   - 9 JMP, A JZ, B JC, C JN, D CLC, F HALT.
//   - E is reserved and executes as NOP.
//  State flow:
//   - FETCH: _oPAddr=PC.
//   - LOAD: IR<=_iPData.
//   - DECODE:
//     - M=1 and LD/ALU: go to MEMRD.
//     - M=0 and LD/ALU: opB<=op, then LD -> WB, ALU -> EXEC.
//   - MEMRD: opB<=_iDRData, then LD -> WB, ALU -> EXEC.
//   - EXEC: _oAluEn=1 for exactly 1 cycle.
//   - WB: LD/ALU -> acc; PC+1; -> FETCH.
//  Executed in DECODE (then -> FETCH unless noted):
//   - ST: _oDWe=1 for 1 cycle; PC+1.
//   - JMP: PC<=op[PC_WIDTH-1:0] (zero-extended if PC_WIDTH>8).
//   - Jcc: taken iff its flag=1, else PC+1.
//   - CLC: C<=0; PC+1.
//   - NOP: PC+1.
//   - HALT: -> HALT, PC unchanged.
//  Latency (cycles per instruction):
//   - LD: imm 4, mem 5.
//   - ALU op: imm 5, mem 6.
//   - ST, NOP, CLC, Jxx, HALT: 3.
//  Flags:
//   - ALU ops: C/Z/N<=alu flags in WB.
//   - LD: Z=(val==0), N=val[7]; C unchanged.
//   - _oAluC=C, so ADD/SUB chain carry/borrow.
//  _oAluEn and _oDWe are decoded from registered state only; never high together.
//  HALT is left only by reset; inputs ignored, no strobes.
//  Reset:
//   - Registers: state FETCH; PC, acc, IR, opB and flags 0.
//   - Outputs: _oAluEn=0, _oDWe=0, _oHalted=0.
//   - Reset in any state aborts the instruction: no write, no PC/acc/flag update.
//  PC+1 at 2**PC_WIDTH-1 wraps to 0.
// STRUCTURE
//  cpu_pkg gains:
//   - Opcode enum (Opcode_NOP..Opcode_HALT).
//   - CtrlState enum (FETCH, LOAD, DECODE, MEMRD, EXEC, WB, HALT).
//   - Instruction field index constants.
//  Reuse the existing Operation type.
//  Single module; no sub-module. Opcode->Operation mapping is a function in cpu_pkg.
// TESTING
//  1. Program LD #5; ADD #3; ST [0x10]; HALT -> RAM[0x10]=8, acc=8, C=0, _oHalted rises 15 cycles after reset release.
//  2. LD #0xFF; ADD #1 -> acc=0, C=1, Z=1; then ADD #0 -> acc=1, C=0, Z=0; CLC then ADD #0 -> acc unchanged.
//  3. RAM[0x20]=0x0F; LD #0xF0; XOR [0x20] -> acc=0xFF, N=1, Z=0, C=0; LD ALU op takes 6 cycles.
//  4. JZ with Z=0 -> PC+1; JZ with Z=1 -> PC=target; JMP 0xFF then NOP -> PC wraps to 0.
//  5. Reset asserted during ST's DECODE -> _oDWe=0 at that edge, RAM unchanged, PC=0, acc=0.
//  6. Opcode 0xE behaves as NOP; after HALT, PC and acc frozen for 100 cycles despite changing _iPData.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU: alu operations, opcodes,
// sequencer states and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        Operation_ADD,
        Operation_SUB,
        Operation_NOR,
        Operation_NAND,
        Operation_XOR,
        Operation_XNOR
    } Operation;

    typedef enum logic [3:0] {
        Opcode_NOP  = 4'h0,
        Opcode_LD   = 4'h1,
        Opcode_ST   = 4'h2,
        Opcode_ADD  = 4'h3,
        Opcode_SUB  = 4'h4,
        Opcode_NOR  = 4'h5,
        Opcode_NAND = 4'h6,
        Opcode_XOR  = 4'h7,
        Opcode_XNOR = 4'h8,
        Opcode_JMP  = 4'h9,
        Opcode_JZ   = 4'hA,
        Opcode_JC   = 4'hB,
        Opcode_JN   = 4'hC,
        Opcode_CLC  = 4'hD,
        Opcode_RSVD = 4'hE,
        Opcode_HALT = 4'hF
    } Opcode;

    typedef enum logic [2:0] {
        FETCH,
        LOAD,
        DECODE,
        MEMRD,
        EXEC,
        WB,
        HALT
    } CtrlState;

    localparam int INSTR_OPC_MSB  = 15;
    localparam int INSTR_OPC_LSB  = 12;
    localparam int INSTR_M_BIT    = 11;
    localparam int INSTR_OPND_MSB = 7;
    localparam int INSTR_OPND_LSB = 0;

    function automatic logic opcode_is_alu(Opcode opc);
        return (opc >= Opcode_ADD) && (opc <= Opcode_XNOR);
    endfunction

    function automatic Operation opcode_to_operation(Opcode opc);
        case (opc)
            Opcode_SUB:  return Operation_SUB;
            Opcode_NOR:  return Operation_NOR;
            Opcode_NAND: return Operation_NAND;
            Opcode_XOR:  return Operation_XOR;
            Opcode_XNOR: return Operation_XNOR;
            default:     return Operation_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU; owns PC,
// accumulator, operand register and C/Z/N flags.
//
//  state  | meaning
//  FETCH  | PC on ROM address
//  LOAD   | ROM word valid, captured into IR
//  DECODE | branch/ST/CLC/NOP/HALT complete here; LD/ALU pick operand source
//  MEMRD  | RAM word valid, captured into operand register
//  EXEC   | alu enable pulse
//  WB     | accumulator and flags updated, PC advances
//  HALT   | frozen until reset
module cpu_control
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int DADDR_WIDTH = 8
) (
    input  logic                   _iClk,
    input  logic                   _iReset,
    output logic [PC_WIDTH-1:0]    _oPAddr,
    input  logic [15:0]            _iPData,
    output logic [DADDR_WIDTH-1:0] _oDAddr,
    output logic                   _oDWe,
    output logic [7:0]             _oDWData,
    input  logic [7:0]             _iDRData,
    output logic                   _oAluEn,
    output Operation               _oAluOp,
    output logic [7:0]             _oAluA,
    output logic [7:0]             _oAluB,
    output logic                   _oAluC,
    input  logic [7:0]             _iAluResult,
    input  logic                   _iAluCarry,
    input  logic                   _iAluZero,
    input  logic                   _iAluNeg,
    output logic [7:0]             _oAcc,
    output logic [PC_WIDTH-1:0]    _oPc,
    output logic                   _oHalted
);

    CtrlState            state;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          acc;
    logic [15:0]         ir;
    logic [7:0]          opb;
    logic                flag_c;
    logic                flag_z;
    logic                flag_n;
    logic                alu_en_q;
    logic                dwe_q;

    Opcode               opc;
    logic [7:0]          opnd;
    logic                is_ld;
    logic                is_alu;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target;
    logic                unused_ir;

    assign opc       = Opcode'(ir[INSTR_OPC_MSB:INSTR_OPC_LSB]);
    assign opnd      = ir[INSTR_OPND_MSB:INSTR_OPND_LSB];
    assign is_ld     = (opc == Opcode_LD);
    assign is_alu    = opcode_is_alu(opc);
    assign pc_inc    = pc + PC_WIDTH'(1);
    assign target    = PC_WIDTH'(opnd);
    assign unused_ir = ^ir[10:8];

    always_ff @(posedge _iClk) begin
        if (_iReset) begin
            state    <= FETCH;
            pc       <= '0;
            acc      <= '0;
            ir       <= '0;
            opb      <= '0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            alu_en_q <= 1'b0;
            dwe_q    <= 1'b0;
        end else begin
            alu_en_q <= 1'b0;
            dwe_q    <= 1'b0;
            case (state)
                FETCH: state <= LOAD;
                LOAD: begin
                    ir    <= _iPData;
                    dwe_q <= (Opcode'(_iPData[INSTR_OPC_MSB:INSTR_OPC_LSB]) == Opcode_ST);
                    state <= DECODE;
                end
                DECODE: begin
                    state <= FETCH;
                    case (opc)
                        Opcode_LD, Opcode_ADD, Opcode_SUB, Opcode_NOR,
                        Opcode_NAND, Opcode_XOR, Opcode_XNOR: begin
                            if (ir[INSTR_M_BIT]) begin
                                state <= MEMRD;
                            end else begin
                                opb      <= opnd;
                                state    <= is_ld ? WB : EXEC;
                                alu_en_q <= is_alu;
                            end
                        end
                        Opcode_JMP:  pc <= target;
                        Opcode_JZ:   pc <= flag_z ? target : pc_inc;
                        Opcode_JC:   pc <= flag_c ? target : pc_inc;
                        Opcode_JN:   pc <= flag_n ? target : pc_inc;
                        Opcode_CLC: begin
                            flag_c <= 1'b0;
                            pc     <= pc_inc;
                        end
                        Opcode_HALT: state <= HALT;
                        default:     pc <= pc_inc;
                    endcase
                end
                MEMRD: begin
                    opb      <= _iDRData;
                    state    <= is_ld ? WB : EXEC;
                    alu_en_q <= is_alu;
                end
                EXEC: state <= WB;
                WB: begin
                    if (is_ld) begin
                        acc    <= opb;
                        flag_z <= (opb == 8'h00);
                        flag_n <= opb[7];
                    end else begin
                        acc    <= _iAluResult;
                        flag_c <= _iAluCarry;
                        flag_z <= _iAluZero;
                        flag_n <= _iAluNeg;
                    end
                    pc    <= pc_inc;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes are suppressed in the cycle a reset is being applied so an
    // aborted ST never reaches the RAM.
    assign _oDWe    = dwe_q & ~_iReset;
    assign _oAluEn  = alu_en_q & ~_iReset;
    assign _oPAddr  = pc;
    assign _oPc     = pc;
    assign _oDAddr  = DADDR_WIDTH'(opnd);
    assign _oDWData = acc;
    assign _oAluOp  = opcode_to_operation(opc);
    assign _oAluA   = acc;
    assign _oAluB   = opb;
    assign _oAluC   = flag_c;
    assign _oAcc    = acc;
    assign _oHalted = (state == HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: ROM/RAM/alu responders plus an instruction-level
// reference model checked every cycle, and directed programs with literal checks.
module tb_cpu_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] paddr;
    logic [15:0] pdata;
    logic [7:0] daddr;
    logic       dwe;
    logic [7:0] dwdata;
    logic [7:0] drdata;
    logic       alu_en;
    Operation   alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_cin;
    logic [7:0] alu_res;
    logic       alu_c, alu_z, alu_n;
    logic [7:0] acc, pc;
    logic       halted;

    logic [15:0] rom [256];
    logic [7:0]  ram [256];
    logic [7:0]  ram_init [256];
    logic        load_mem = 1'b0;
    logic        scramble = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_pc, m_acc;
    logic       m_c, m_z, m_n, m_halt;
    logic [7:0] m_ram [256];
    int         phase;

    cpu_control dut (
        ._iClk(clk), ._iReset(rst),
        ._oPAddr(paddr), ._iPData(pdata),
        ._oDAddr(daddr), ._oDWe(dwe), ._oDWData(dwdata), ._iDRData(drdata),
        ._oAluEn(alu_en), ._oAluOp(alu_op), ._oAluA(alu_a), ._oAluB(alu_b), ._oAluC(alu_cin),
        ._iAluResult(alu_res), ._iAluCarry(alu_c), ._iAluZero(alu_z), ._iAluNeg(alu_n),
        ._oAcc(acc), ._oPc(pc), ._oHalted(halted)
    );

    always #5 clk = ~clk;

    // returns {neg, zero, carry, result}
    function automatic logic [10:0] alu_ref(Operation op, logic [7:0] a, logic [7:0] b, logic cin);
        logic [8:0] w;
        case (op)
            Operation_ADD:  w = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            Operation_SUB:  w = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            Operation_NOR:  w = {1'b0, ~(a | b)};
            Operation_NAND: w = {1'b0, ~(a & b)};
            Operation_XOR:  w = {1'b0, a ^ b};
            default:        w = {1'b0, ~(a ^ b)};
        endcase
        return {w[7], (w[7:0] == 8'h00), w[8], w[7:0]};
    endfunction

    always @(posedge clk) begin
        pdata  <= scramble ? 16'($urandom) : rom[paddr];
        drdata <= ram[daddr];
        if (load_mem) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
        end else if (dwe) begin
            ram[daddr] <= dwdata;
        end
        if (alu_en) {alu_n, alu_z, alu_c, alu_res} <= alu_ref(alu_op, alu_a, alu_b, alu_cin);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(logic [3:0] opn, logic m, logic [7:0] opd);
        return {opn, m, 3'b000, opd};
    endfunction

    function automatic int lat_of(logic [15:0] w);
        if (w[15:12] == 4'h1) return w[11] ? 5 : 4;
        if (w[15:12] >= 4'h3 && w[15:12] <= 4'h8) return w[11] ? 6 : 5;
        return 3;
    endfunction

    function automatic Operation op_of(logic [3:0] opn);
        case (opn)
            4'h4:    return Operation_SUB;
            4'h5:    return Operation_NOR;
            4'h6:    return Operation_NAND;
            4'h7:    return Operation_XOR;
            4'h8:    return Operation_XNOR;
            default: return Operation_ADD;
        endcase
    endfunction

    // One whole instruction at ISA level.
    task automatic model_exec();
        logic [15:0] w;
        logic [3:0]  opn;
        logic [7:0]  opd, val;
        w   = rom[m_pc];
        opn = w[15:12];
        opd = w[7:0];
        val = w[11] ? m_ram[opd] : opd;
        case (opn)
            4'h1: begin m_acc = val; m_z = (val == 8'h00); m_n = val[7]; m_pc++; end
            4'h2: begin m_ram[opd] = m_acc; m_pc++; end
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                {m_n, m_z, m_c, m_acc} = alu_ref(op_of(opn), m_acc, val, m_c);
                m_pc++;
            end
            4'h9: m_pc = opd;
            4'hA: m_pc = m_z ? opd : m_pc + 8'd1;
            4'hB: m_pc = m_c ? opd : m_pc + 8'd1;
            4'hC: m_pc = m_n ? opd : m_pc + 8'd1;
            4'hD: begin m_c = 1'b0; m_pc++; end
            4'hF: m_halt = 1'b1;
            default: m_pc++;
        endcase
    endtask

    initial begin : cmp
        logic rst_s, load_s;
        logic [15:0] w;
        forever begin
            @(posedge clk);
            rst_s  = rst;
            load_s = load_mem;
            #1;
            if (rst_s) begin
                m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_n = 0; m_halt = 0; phase = 0;
                if (load_s) for (int i = 0; i < 256; i++) m_ram[i] = ram_init[i];
                check("rst_pc", pc, 0);
                check("rst_acc", acc, 0);
                check("rst_halted", halted, 0);
                check("rst_alu_en", alu_en, 0);
                check("rst_dwe", dwe, 0);
            end else if (m_halt) begin
                check("halt_pc", pc, m_pc);
                check("halt_acc", acc, m_acc);
                check("halt_flag", halted, 1);
                check("halt_strobes", {alu_en, dwe}, 0);
            end else begin
                phase++;
                if (phase == lat_of(rom[m_pc])) begin
                    model_exec();
                    phase = 0;
                    check("instr_pc", pc, m_pc);
                    check("instr_acc", acc, m_acc);
                    check("instr_carry", alu_cin, m_c);
                    check("instr_halted", halted, m_halt);
                end
                if (!m_halt) begin
                    w = rom[m_pc];
                    check("alu_en", alu_en,
                          (w[15:12] >= 4'h3 && w[15:12] <= 4'h8 && phase == lat_of(w) - 2));
                    check("dwe", dwe, (w[15:12] == 4'h2 && phase == 2));
                    if (w[15:12] == 4'h2 && phase == 2) begin
                        check("st_addr", daddr, w[7:0]);
                        check("st_data", dwdata, m_acc);
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'h0000;
            ram_init[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load_mem = 1'b1;
        repeat (2) @(negedge clk);
        load_mem = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int bound, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < bound) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("halt_reached", halted, 1);
    endtask

    task automatic check_ram(string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        clear_mem();

        // LD #5; ADD #3; ST [0x10]; HALT
        rom[0] = ins(4'h1, 0, 8'd5);
        rom[1] = ins(4'h3, 0, 8'd3);
        rom[2] = ins(4'h2, 1, 8'h10);
        rom[3] = ins(4'hF, 0, 8'h00);
        do_reset();
        wait_halt(200, cyc);
        check("t1_halt_cycles", cyc, 15);
        check("t1_ram10", ram[8'h10], 8'h08);
        check("t1_acc", acc, 8'h08);
        check("t1_carry", alu_cin, 0);
        check_ram("t1_ram");

        // carry chain, JZ/JC taken, CLC
        clear_mem();
        rom[0]  = ins(4'h1, 0, 8'hFF);
        rom[1]  = ins(4'h3, 0, 8'h01);
        rom[2]  = ins(4'hA, 0, 8'd4);
        rom[3]  = ins(4'hF, 0, 8'h00);
        rom[4]  = ins(4'hB, 0, 8'd6);
        rom[5]  = ins(4'hF, 0, 8'h00);
        rom[6]  = ins(4'h3, 0, 8'h00);
        rom[7]  = ins(4'h2, 1, 8'h40);
        rom[8]  = ins(4'h1, 0, 8'hFF);
        rom[9]  = ins(4'h3, 0, 8'h01);
        rom[10] = ins(4'hD, 0, 8'h00);
        rom[11] = ins(4'h3, 0, 8'h00);
        rom[12] = ins(4'h2, 1, 8'h41);
        rom[13] = ins(4'hF, 0, 8'h00);
        ram_init[8'h40] = 8'h55;
        ram_init[8'h41] = 8'h55;
        do_reset();
        wait_halt(400, cyc);
        check("t2_halt_cycles", cyc, 46);
        check("t2_pc", pc, 8'd13);
        check("t2_ram40", ram[8'h40], 8'h01);
        check("t2_ram41", ram[8'h41], 8'h00);
        check("t2_acc", acc, 8'h00);
        check("t2_carry", alu_cin, 0);
        check_ram("t2_ram");

        // memory operand XOR, JN taken, JZ not taken
        clear_mem();
        rom[0] = ins(4'h1, 0, 8'hF0);
        rom[1] = ins(4'h7, 1, 8'h20);
        rom[2] = ins(4'hC, 0, 8'd4);
        rom[3] = ins(4'hF, 0, 8'h00);
        rom[4] = ins(4'hA, 0, 8'd3);
        rom[5] = ins(4'h2, 1, 8'h21);
        rom[6] = ins(4'hF, 0, 8'h00);
        ram_init[8'h20] = 8'h0F;
        do_reset();
        wait_halt(400, cyc);
        check("t3_halt_cycles", cyc, 22);
        check("t3_pc", pc, 8'd6);
        check("t3_ram21", ram[8'h21], 8'hFF);
        check("t3_acc", acc, 8'hFF);
        check("t3_carry", alu_cin, 0);
        check_ram("t3_ram");

        // JZ not taken / taken, JMP 0xFF then NOP wraps PC to 0
        clear_mem();
        rom[8'h00] = ins(4'hA, 0, 8'h20);
        rom[8'h01] = ins(4'h1, 0, 8'h00);
        rom[8'h02] = ins(4'hA, 0, 8'h10);
        rom[8'h10] = ins(4'h9, 0, 8'hFF);
        rom[8'hFF] = ins(4'h0, 0, 8'h00);
        rom[8'h20] = ins(4'hF, 0, 8'h00);
        do_reset();
        wait_halt(400, cyc);
        check("t4_halt_cycles", cyc, 22);
        check("t4_pc", pc, 8'h20);

        // reset during ST's DECODE aborts the write
        clear_mem();
        rom[0] = ins(4'h1, 0, 8'h77);
        rom[1] = ins(4'h2, 1, 8'h30);
        rom[2] = ins(4'hF, 0, 8'h00);
        ram_init[8'h30] = 8'h11;
        do_reset();
        repeat (6) @(posedge clk);
        #2;
        check("t5_dwe_decode", dwe, 1);
        check("t5_acc_before", acc, 8'h77);
        rst = 1'b1;
        #1;
        check("t5_dwe_in_reset", dwe, 0);
        @(posedge clk);
        #2;
        check("t5_ram30", ram[8'h30], 8'h11);
        check("t5_pc", pc, 8'h00);
        check("t5_acc", acc, 8'h00);
        check_ram("t5_ram");

        // reserved opcode as NOP, then HALT frozen under changing ROM data
        clear_mem();
        rom[0] = ins(4'hE, 1, 8'h99);
        rom[1] = ins(4'h1, 0, 8'h42);
        rom[2] = ins(4'hF, 0, 8'h00);
        do_reset();
        wait_halt(200, cyc);
        check("t6_halt_cycles", cyc, 10);
        scramble = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        check("t6_pc", pc, 8'd2);
        check("t6_acc", acc, 8'h42);
        check("t6_halted", halted, 1);
        scramble = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
